// File: rtl/wirecube_vertex_sched_if.sv
// Datapath handshake between the vertex scheduler (master) and the rotate/project unit (slave).
// req/vtx_idx/angle flow downstream; ack returns as a 1-cycle completion pulse.
interface wirecube_vertex_sched_if #(
    parameter int IDX_W   = 4,
    parameter int ANGLE_W = 8
);
    logic               req;
    logic [IDX_W-1:0]   vtx_idx;
    logic [ANGLE_W-1:0] angle;
    logic               ack;

    modport master (output req, vtx_idx, angle, input ack);
    modport slave  (input req, vtx_idx, angle, output ack);
endinterface

// File: rtl/wirecube_vertex_sched.sv
// Per-frame sequencer: advances the cube angle, issues one req/ack per vertex, then pulses commit.
// Latency: req one cycle after the frame pulse; commit one cycle after the last ack (1+NUM_VTX+1 minimum).
// Backpressure: req/idx/angle hold until ack; frame pulses while busy are dropped and flagged
// (WIRECUBE_SCHED_OVERRUN_CNT_EN adds a saturating rejected-pulse counter).
module wirecube_vertex_sched #(
    parameter int NUM_VTX = 8,
    parameter int ANGLE_W = 8,
    parameter int IDX_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     next_frame_i,
    input  logic [3:0]               speed_i,
    input  logic                     dir_i,
    input  logic                     pause_i,
    wirecube_vertex_sched_if.master  dp,
    output logic                     busy_o,
    output logic                     commit_o,
    output logic                     overrun_o
`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]               overrun_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;
    logic                 overrun_q, overrun_d;
    logic [ANGLE_W-1:0]   speed_ext;
    logic                 last_vtx;
    logic                 frame_rejected;

    assign speed_ext      = ANGLE_W'(speed_i);
    assign last_vtx       = (idx_q == IDX_W'(NUM_VTX - 1));
    assign frame_rejected = next_frame_i && (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            angle_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            angle_q   <= angle_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        angle_d   = angle_q;
        overrun_d = overrun_q | frame_rejected;
        case (state_q)
            IDLE: begin
                if (next_frame_i) begin
                    // Wraps naturally modulo 2**ANGLE_W in both directions.
                    if (!pause_i) begin
                        angle_d = dir_i ? (angle_q - speed_ext) : (angle_q + speed_ext);
                    end
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dp.ack) begin
                    if (last_vtx) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode straight from registered state, so they are glitch-free.
    assign dp.req     = (state_q == ISSUE);
    assign dp.vtx_idx = idx_q;
    assign dp.angle   = angle_q;
    assign busy_o     = (state_q != IDLE);
    assign commit_o   = (state_q == COMMIT);
    assign overrun_o  = overrun_q;

`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr_cnt_q <= '0;
        end else if (frame_rejected && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_wirecube_vertex_sched.sv
// Directed bench for wirecube_vertex_sched: reset, single frame, wrap/direction, pause with ack stall,
// overrun, and reset in the middle of a vertex sequence.
`timescale 1ns/1ps
module tb_wirecube_vertex_sched;
    localparam int NUM_VTX = 8;
    localparam int ANGLE_W = 8;
    localparam int IDX_W   = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       next_frame_i = 1'b0;
    logic [3:0] speed_i = 4'd0;
    logic       dir_i = 1'b0;
    logic       pause_i = 1'b0;
    logic       busy_o, commit_o, overrun_o;
`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_o;
`endif

    wirecube_vertex_sched_if #(.IDX_W(IDX_W), .ANGLE_W(ANGLE_W)) dp ();

    wirecube_vertex_sched #(.NUM_VTX(NUM_VTX), .ANGLE_W(ANGLE_W), .IDX_W(IDX_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .next_frame_i (next_frame_i),
        .speed_i      (speed_i),
        .dir_i        (dir_i),
        .pause_i      (pause_i),
        .dp           (dp.master),
        .busy_o       (busy_o),
        .commit_o     (commit_o),
        .overrun_o    (overrun_o)
`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
        ,
        .overrun_cnt_o(overrun_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cyc = 0;
    int commit_cyc = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse next_frame for one cycle, then scramble the controls to show they are sampled only on the pulse.
    task automatic frame(input logic [3:0] s, input logic d, input logic p);
        next_frame_i = 1'b1;
        speed_i = s;
        dir_i = d;
        pause_i = p;
        pulse_cyc = cyc;
        tick();
        next_frame_i = 1'b0;
        speed_i = ~s;
        dir_i = ~d;
        pause_i = ~p;
    endtask

    // Walk all vertices; ovr_vtx injects a frame pulse alongside that vertex's ack, ovr_commit one in the commit cycle.
    task automatic run_seq(input string tag, input logic [7:0] exp_angle, input int ack_delay,
                           input int ovr_vtx, input bit ovr_commit);
        for (int v = 0; v < NUM_VTX; v++) begin
            for (int d = 0; d < ack_delay; d++) begin
                chk({tag, "_wait_req"}, dp.req, 1'b1);
                chk({tag, "_wait_idx"}, dp.vtx_idx, v);
                chk({tag, "_wait_angle"}, dp.angle, exp_angle);
                tick();
            end
            chk({tag, "_req"}, dp.req, 1'b1);
            chk({tag, "_idx"}, dp.vtx_idx, v);
            chk({tag, "_angle"}, dp.angle, exp_angle);
            dp.ack = 1'b1;
            if (v == ovr_vtx) begin
                next_frame_i = 1'b1;
                speed_i = 4'd15;
                dir_i = 1'b0;
                pause_i = 1'b0;
            end
            tick();
            dp.ack = 1'b0;
            next_frame_i = 1'b0;
        end
        chk({tag, "_commit"}, commit_o, 1'b1);
        chk({tag, "_commit_req"}, dp.req, 1'b0);
        chk({tag, "_commit_busy"}, busy_o, 1'b1);
        chk({tag, "_commit_angle"}, dp.angle, exp_angle);
        commit_cyc = cyc;
        if (ovr_commit) begin
            next_frame_i = 1'b1;
            speed_i = 4'd15;
            pause_i = 1'b0;
        end
        tick();
        next_frame_i = 1'b0;
        chk({tag, "_end_commit"}, commit_o, 1'b0);
        chk({tag, "_end_busy"}, busy_o, 1'b0);
        chk({tag, "_end_req"}, dp.req, 1'b0);
    endtask

    initial begin
        dp.ack = 1'b0;

        // T1 reset: two cycles high, then idle acks must do nothing
        rst_i = 1'b1;
        tick();
        tick();
        chk("t1_req", dp.req, 1'b0);
        chk("t1_idx", dp.vtx_idx, 4'd0);
        chk("t1_angle", dp.angle, 8'd0);
        chk("t1_busy", busy_o, 1'b0);
        chk("t1_commit", commit_o, 1'b0);
        chk("t1_overrun", overrun_o, 1'b0);
`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
        chk("t1_ovr_cnt", overrun_cnt_o, 8'd0);
`endif
        rst_i = 1'b0;
        dp.ack = 1'b1;
        tick();
        tick();
        tick();
        dp.ack = 1'b0;
        chk("t1_ack_req", dp.req, 1'b0);
        chk("t1_ack_idx", dp.vtx_idx, 4'd0);
        chk("t1_ack_busy", busy_o, 1'b0);
        chk("t1_ack_commit", commit_o, 1'b0);

        // T2 single frame: 0+3 = 3; commit falls in the 10th cycle counting the pulse cycle as the 1st
        frame(4'd3, 1'b0, 1'b0);
        run_seq("t2", 8'd3, 0, -1, 1'b0);
        chk("t2_commit_lat", commit_cyc - pulse_cyc, 9);

        // T3 wrap and direction: 3-5 = 254, 254+5 = 3, 3-4 = 255
        frame(4'd5, 1'b1, 1'b0);
        run_seq("t3a", 8'd254, 0, -1, 1'b0);
        frame(4'd5, 1'b0, 1'b0);
        run_seq("t3b", 8'd3, 0, -1, 1'b0);
        frame(4'd4, 1'b1, 1'b0);
        run_seq("t3c", 8'd255, 0, -1, 1'b0);

        // T4 pause with 5-cycle ack stall: angle stays 255; 1 + 8*6 cycles to commit
        frame(4'd7, 1'b0, 1'b1);
        run_seq("t4", 8'd255, 5, -1, 1'b0);
        chk("t4_commit_lat", commit_cyc - pulse_cyc, 49);

        // T5 overrun at vertex 4 and in the commit cycle: 255+2 = 1, rejected pulses leave it alone
        frame(4'd2, 1'b0, 1'b0);
        run_seq("t5", 8'd1, 0, 4, 1'b1);
        chk("t5_overrun", overrun_o, 1'b1);
        chk("t5_angle_kept", dp.angle, 8'd1);
`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
        chk("t5_ovr_cnt", overrun_cnt_o, 8'd2);
`endif
        tick();
        chk("t5_no_restart", dp.req, 1'b0);
        chk("t5_overrun_sticky", overrun_o, 1'b1);

        // T6 reset at vertex 5: 1+6 = 7 before reset, then 0+6 = 6 after
        frame(4'd6, 1'b0, 1'b0);
        for (int v = 0; v < 5; v++) begin
            dp.ack = 1'b1;
            tick();
        end
        dp.ack = 1'b0;
        chk("t6_pre_idx", dp.vtx_idx, 4'd5);
        chk("t6_pre_angle", dp.angle, 8'd7);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_req", dp.req, 1'b0);
        chk("t6_idx", dp.vtx_idx, 4'd0);
        chk("t6_angle", dp.angle, 8'd0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_commit", commit_o, 1'b0);
        chk("t6_overrun", overrun_o, 1'b0);
`ifdef WIRECUBE_SCHED_OVERRUN_CNT_EN
        chk("t6_ovr_cnt", overrun_cnt_o, 8'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_commit", commit_o, 1'b0);
        end
        frame(4'd6, 1'b0, 1'b0);
        run_seq("t6_next", 8'd6, 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
